debug_view_manager: RTL
=======================

DEBUG_VIEW_MANAGER -- requirements
Module: debug_view_manager

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of selectable CPU registers, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: register width, even, 8..32.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable cycles needed to accept a button level (10 ms at 100 MHz).
REQ-004 SHALL have parameter FLASH_CYCLES, default 50000000: flash duration after a value change (0.5 s).
REQ-005 SHALL have local parameter IDX_W = clog2(NUM_REGS).
REQ-006 clock_100mhz  input  1  sole clock; all state on the rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 reg_file  input  NUM_REGS*DATA_W  flattened registers; register i at bits [i*DATA_W +: DATA_W].
REQ-009 pc  input  32  CPU program counter.
REQ-010 buttons  input  5  raw asynchronous pushbuttons: [0] center, [1] up, [2] right, [3] down, [4] left.
REQ-011 view_word  output  DATA_W  word driven to the seven-segment display.
REQ-012 view_idx  output  IDX_W  index of the selected register.
REQ-013 flash_upper  output  1  upper half of view_word changed recently.
REQ-014 flash_lower  output  1  lower half of view_word changed recently.
REQ-015 mono_leds  output  16  LED bar contents.
REQ-016 frozen  output  1  high in FROZEN state.

Function
REQ-017 SHALL pass each button through a two-flop synchroniser, then a per-button debouncer: the debounced level takes the synchronised level after DEBOUNCE_CYCLES consecutive equal samples that differ from it; any mismatch restarts that button's counter.
REQ-018 SHALL generate a one-cycle press pulse on each 0->1 debounced transition; releases generate nothing.
REQ-019 up press: view_idx increments, wrapping NUM_REGS-1 -> 0; down press: view_idx decrements, wrapping 0 -> NUM_REGS-1.
REQ-020 center press: view_idx <= 0 and state <= LIVE.
REQ-021 Same-cycle presses: center beats up and down; up beats down; left and right act independently of the index presses.
REQ-022 SHALL implement two states, LIVE and FROZEN; a left press toggles LIVE<->FROZEN unless center is pressed in the same cycle.
REQ-023 LIVE: view_word <= selected register each cycle (one cycle latency from reg_file or view_idx change).
REQ-024 FROZEN: view_word holds its value at entry; up and down still change view_idx, and view_word loads the newly selected register once on each index change.
REQ-025 right press toggles led_mode: 0 -> mono_leds = pc[15:0]; 1 -> mono_leds = view_word[15:0], zero-extended when DATA_W < 16.
REQ-026 Change detection, LIVE only, index unchanged since the previous cycle: a change in view_word[DATA_W-1:DATA_W/2] loads the upper flash timer with FLASH_CYCLES; a change in the lower half loads the lower timer; a repeat change reloads the timer.
REQ-027 flash_upper and flash_lower are high while their timer is nonzero; timers decrement to 0 and saturate there.
REQ-028 Any view_idx change or state change clears both timers in that cycle and does not itself trigger a flash.
REQ-029 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-030 reset_n low, asynchronously: view_idx=0, view_word=0, flash_upper=0, flash_lower=0, mono_leds=0, frozen=0, state=LIVE, led_mode=0, debounced levels=0, all counters and timers=0.
REQ-031 Reset asserted mid-debounce or mid-flash abandons the operation; the first press after release needs a full DEBOUNCE_CYCLES.
REQ-032 After reset release, view_word shows register 0 on the second rising edge.

Verification (DEBOUNCE_CYCLES=4, FLASH_CYCLES=8, NUM_REGS=5, DATA_W=32)
REQ-033 Up held 3 cycles, then 10 cycles -> no index change on the 3-cycle pulse; view_idx=1 after the 10-cycle pulse.
REQ-034 Five clean up presses from idx 0 -> 1,2,3,4,0; one down press from 0 -> 4.
REQ-035 Register 2 = 0x0000_1234 live, then changes to 0x0000_1235 -> flash_lower high for 8 cycles; flash_upper stays 0.
REQ-036 Left press, then register 0 changes from 0xAAAA_0000 to 0x5555_0000 -> frozen=1; view_word stays 0xAAAA_0000; no flash.
REQ-037 Center and up debounced in the same cycle from idx 3 -> view_idx=0; right press -> mono_leds = view_word[15:0].
REQ-038 reset_n pulsed low during a flash -> all outputs 0 immediately; no flash after release.

Source files
------------

// File: rtl/debug_view_manager.sv
// ============================================================================
// debug_view_manager
//
// Purpose:
//   Front-panel debug viewer for a soft CPU. Five pushbuttons pick one
//   register out of the CPU register file. That register is shown on the
//   seven-segment display, either live or frozen. When a displayed half-word
//   changes, its flash output goes high for a while. The LED bar shows either
//   the program counter or the low 16 bits of the displayed word.
//
// Ports:
//   clock_100mhz  in   1                 sole clock, rising edge
//   reset_n       in   1                 asynchronous active-low reset
//   reg_file      in   NUM_REGS*DATA_W   register i at [i*DATA_W +: DATA_W]
//   pc            in   32                CPU program counter
//   buttons       in   5                 raw buttons: 0 center, 1 up,
//                                        2 right, 3 down, 4 left
//   view_word     out  DATA_W            word for the seven-segment display
//   view_idx      out  IDX_W             index of the selected register
//   flash_upper   out  1                 upper half changed recently
//   flash_lower   out  1                 lower half changed recently
//   mono_leds     out  16                LED bar contents
//   frozen        out  1                 high while the view is frozen
// ============================================================================
module debug_view_manager #(
    parameter int NUM_REGS        = 8,
    parameter int DATA_W          = 32,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FLASH_CYCLES    = 50000000,
    localparam int IDX_W          = $clog2(NUM_REGS)
) (
    input  logic                         clock_100mhz,
    input  logic                         reset_n,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_file,
    input  logic [31:0]                  pc,
    input  logic [4:0]                   buttons,
    output logic [DATA_W-1:0]            view_word,
    output logic [IDX_W-1:0]             view_idx,
    output logic                         flash_upper,
    output logic                         flash_lower,
    output logic [15:0]                  mono_leds,
    output logic                         frozen
);

    localparam int BTN_CENTER = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_LEFT   = 4;

    localparam int HALF = DATA_W / 2;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FL_W = $clog2(FLASH_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FL_W-1:0]  FL_LOAD   = FL_W'(FLASH_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } view_state_t;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [4:0]      sync1;
    logic [4:0]      sync2;
    logic [4:0]      db_level;
    logic [4:0]      db_prev;
    logic [DB_W-1:0] db_cnt [5];
    logic [4:0]      press;

    // The debounce counter runs only while the synchronised level differs
    // from the accepted level. Any sample equal to the accepted level
    // restarts the count.
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= buttons;
            sync2   <= sync1;
            db_prev <= db_level;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the single cycle after a debounced rising edge.
    assign press = db_level & ~db_prev;

    // ------------------------------------------------------------------
    // Register selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] selected;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
        assign regs[g] = reg_file[g*DATA_W +: DATA_W];
    end

    assign selected = regs[view_idx];

    // ------------------------------------------------------------------
    // Control state: view mode, index, LED mode
    // ------------------------------------------------------------------
    view_state_t      state_q;
    view_state_t      state_d;
    logic [IDX_W-1:0] idx_d;
    logic             led_mode;
    logic             led_mode_d;

    // Center overrides up, down and the left toggle. Up wins over down.
    // Right is independent of the other buttons.
    always_comb begin
        state_d    = state_q;
        idx_d      = view_idx;
        led_mode_d = led_mode;

        if (press[BTN_CENTER]) begin
            idx_d   = '0;
            state_d = LIVE;
        end else begin
            if (press[BTN_UP]) begin
                idx_d = (view_idx == IDX_LAST) ? '0 : view_idx + 1'b1;
            end else if (press[BTN_DOWN]) begin
                idx_d = (view_idx == '0) ? IDX_LAST : view_idx - 1'b1;
            end
            if (press[BTN_LEFT]) begin
                state_d = (state_q == LIVE) ? FROZEN : LIVE;
            end
        end

        if (press[BTN_RIGHT]) begin
            led_mode_d = ~led_mode;
        end
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LIVE;
            view_idx <= '0;
            led_mode <= 1'b0;
        end else begin
            state_q  <= state_d;
            view_idx <= idx_d;
            led_mode <= led_mode_d;
        end
    end

    assign frozen = (state_q == FROZEN);

    // ------------------------------------------------------------------
    // Displayed word and change detection
    // ------------------------------------------------------------------
    logic              armed;
    logic              settle;
    logic              idx_moved;
    logic              disturb;
    logic [DATA_W-1:0] word_d;
    logic              hit_upper;
    logic              hit_lower;
    logic [FL_W-1:0]   timer_upper;
    logic [FL_W-1:0]   timer_lower;
    logic [FL_W-1:0]   timer_upper_d;
    logic [FL_W-1:0]   timer_lower_d;

    assign disturb = (idx_d != view_idx) || (state_d != state_q);

    // The display stays at zero for one edge after reset. It starts tracking
    // from the second edge. In FROZEN mode it reloads once, one cycle after
    // each index change. 'settle' marks the first load after a reset, an
    // index change or a mode change. That load is expected, so it must not
    // start a flash.
    always_comb begin
        word_d    = view_word;
        hit_upper = 1'b0;
        hit_lower = 1'b0;

        if (armed && (state_q == LIVE || idx_moved)) begin
            word_d = selected;
        end

        if (state_q == LIVE && !settle && !disturb) begin
            hit_upper = (word_d[DATA_W-1:HALF] != view_word[DATA_W-1:HALF]);
            hit_lower = (word_d[HALF-1:0] != view_word[HALF-1:0]);
        end
    end

    // Timers clear on any disturbance. A new change reloads them.
    // Otherwise they count down and stop at zero.
    always_comb begin
        timer_upper_d = timer_upper;
        timer_lower_d = timer_lower;

        if (disturb) begin
            timer_upper_d = '0;
            timer_lower_d = '0;
        end else begin
            if (hit_upper) begin
                timer_upper_d = FL_LOAD;
            end else if (timer_upper != '0) begin
                timer_upper_d = timer_upper - 1'b1;
            end
            if (hit_lower) begin
                timer_lower_d = FL_LOAD;
            end else if (timer_lower != '0) begin
                timer_lower_d = timer_lower - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            settle      <= 1'b1;
            idx_moved   <= 1'b0;
            view_word   <= '0;
            timer_upper <= '0;
            timer_lower <= '0;
        end else begin
            armed       <= 1'b1;
            settle      <= disturb | ~armed;
            idx_moved   <= (idx_d != view_idx);
            view_word   <= word_d;
            timer_upper <= timer_upper_d;
            timer_lower <= timer_lower_d;
        end
    end

    assign flash_upper = (timer_upper != '0);
    assign flash_lower = (timer_lower != '0);

    // ------------------------------------------------------------------
    // LED bar
    // ------------------------------------------------------------------
    logic [15:0] word_low16;
    logic        unused_pc;

    if (DATA_W >= 16) begin : g_wide
        assign word_low16 = view_word[15:0];
    end else begin : g_narrow
        assign word_low16 = {{(16-DATA_W){1'b0}}, view_word};
    end

    assign unused_pc = ^pc[31:16];

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            mono_leds <= '0;
        end else begin
            mono_leds <= led_mode ? word_low16 : pc[15:0];
        end
    end

endmodule
